// File: rtl/ofdm_symbol_framer.sv
// OFDM burst framer: drops the long-preamble GI and cyclic prefixes, passes LTS and data symbols.
// Optional restart on a mid-burst marker: define OFDM_FRAMER_RETRIGGER_EN.
module ofdm_symbol_framer #(
    parameter int unsigned WIDTH_SAMPLE   = 16,
    parameter int unsigned FFT_LEN        = 64,
    parameter int unsigned LTS_GI_LEN     = 32,
    parameter int unsigned LTS_NUM        = 2,
    parameter int unsigned SR_NUM_SYMBOLS = 8,
    parameter int unsigned SR_CP_LEN      = 9
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic [2*WIDTH_SAMPLE-1:0] i_tdata,
    input  logic                      i_tlast,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    output logic [2*WIDTH_SAMPLE-1:0] o_tdata,
    output logic                      o_tlast,
    output logic [1:0]                o_tuser,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic                      busy,
    output logic                      burst_done
);

    localparam int unsigned CntMax0 = (FFT_LEN > LTS_GI_LEN) ? FFT_LEN : LTS_GI_LEN;
    localparam int unsigned CntMax  = (CntMax0 > 256) ? CntMax0 : 256;
    localparam int unsigned CW      = $clog2(CntMax);
    localparam int unsigned LtsW    = (LTS_NUM > 1) ? $clog2(LTS_NUM) : 1;

    typedef enum logic [2:0] {StIdle, StLtsGi, StLts, StCp, StSym, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   samp_q, samp_d;
    logic [LtsW-1:0] lts_q, lts_d;
    logic [11:0]     sym_q, sym_d;
    logic [11:0]     num_sym_reg, num_sym_q, num_sym_d;
    logic [7:0]      cp_len_reg, cp_len_q, cp_len_d;

    logic   pass, accept, fft_end, start, retrig_ok, mark_abort;
    state_e after_lts, after_sym;
    logic   unused_set_data;

    assign unused_set_data = ^set_data[31:12];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            num_sym_reg <= '0;
            cp_len_reg  <= '0;
        end else if (set_stb) begin
            if (set_addr == 8'(SR_NUM_SYMBOLS)) num_sym_reg <= set_data[11:0];
            if (set_addr == 8'(SR_CP_LEN))      cp_len_reg  <= set_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            samp_q    <= '0;
            lts_q     <= '0;
            sym_q     <= '0;
            num_sym_q <= '0;
            cp_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            lts_q     <= lts_d;
            sym_q     <= sym_d;
            num_sym_q <= num_sym_d;
            cp_len_q  <= cp_len_d;
        end
    end

    assign pass       = (state_q == StLts) || (state_q == StSym);
    assign i_tready   = pass ? o_tready : (state_q != StDone);
    assign accept     = i_tvalid & i_tready;
    assign o_tvalid   = pass & i_tvalid;
    assign o_tdata    = i_tdata;
    assign fft_end    = (samp_q == CW'(FFT_LEN - 1));
    assign busy       = (state_q != StIdle);
    assign burst_done = (state_q == StDone);

`ifdef OFDM_FRAMER_RETRIGGER_EN
    assign retrig_ok  = (state_q == StLtsGi) || (state_q == StCp) || pass;
    assign mark_abort = pass & i_tlast;
`else
    assign retrig_ok  = 1'b0;
    assign mark_abort = 1'b0;
`endif

    // A marker beat in a pass state closes the partial packet on its own output beat.
    assign o_tlast = pass & (fft_end | mark_abort);
    assign o_tuser = {mark_abort, state_q == StLts};
    assign start   = accept & i_tlast & ((state_q == StIdle) | retrig_ok);

    assign after_lts = (num_sym_q == '0) ? StDone : ((cp_len_q != '0) ? StCp : StSym);
    assign after_sym = (cp_len_q != '0) ? StCp : StSym;

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        lts_d     = lts_q;
        sym_d     = sym_q;
        num_sym_d = num_sym_q;
        cp_len_d  = cp_len_q;
        case (state_q)
            StLtsGi: if (accept) begin
                if (samp_q == CW'(LTS_GI_LEN - 1)) begin
                    state_d = StLts;
                    samp_d  = '0;
                end else begin
                    samp_d = samp_q + CW'(1);
                end
            end
            StLts: if (accept) begin
                if (fft_end) begin
                    samp_d = '0;
                    if (lts_q == LtsW'(LTS_NUM - 1)) begin
                        lts_d   = '0;
                        state_d = after_lts;
                    end else begin
                        lts_d = lts_q + LtsW'(1);
                    end
                end else begin
                    samp_d = samp_q + CW'(1);
                end
            end
            StCp: if (accept) begin
                if (samp_q == CW'(cp_len_q) - CW'(1)) begin
                    state_d = StSym;
                    samp_d  = '0;
                end else begin
                    samp_d = samp_q + CW'(1);
                end
            end
            StSym: if (accept) begin
                if (fft_end) begin
                    samp_d = '0;
                    if (sym_q + 12'd1 == num_sym_q) begin
                        sym_d   = '0;
                        state_d = StDone;
                    end else begin
                        sym_d   = sym_q + 12'd1;
                        state_d = after_sym;
                    end
                end else begin
                    samp_d = samp_q + CW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase
        // The trigger sample itself is guard-interval index 0.
        if (start) begin
            state_d   = (LTS_GI_LEN == 1) ? StLts : StLtsGi;
            samp_d    = (LTS_GI_LEN == 1) ? '0 : CW'(1);
            lts_d     = '0;
            sym_d     = '0;
            num_sym_d = num_sym_reg;
            cp_len_d  = cp_len_reg;
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Randomized bench for ofdm_symbol_framer with a positional burst model built from the framing rules.
module tb_ofdm_symbol_framer;

    localparam int FFT = 64;
    localparam int GI  = 32;
    localparam int LTN = 2;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic [1:0]  o_tuser;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        busy;
    logic        burst_done;

    ofdm_symbol_framer dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tuser    (o_tuser),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .busy       (busy),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] in_d[$];
    bit          in_m[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [1:0]  exp_u[$];
    int          tlast_pos[$];
    int done_exp = 0, done_seen = 0, beats = 0, lts_tagged = 0;
    int last_beat_cyc = 0, done_cyc = 0;
    bit abort = 1'b0;
    bit stall_prev = 1'b0;
    logic [34:0] prev_out;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Compare process: every accepted output beat against the model queue.
    always @(negedge clk) begin
        if (aresetn) begin
            if (o_tvalid && o_tready) begin
                beats++;
                if (exp_d.size() == 0) begin
                    chk("beat_unexpected", {o_tdata, o_tlast, o_tuser}, 64'h0);
                end else begin
                    chk("beat", {o_tdata, o_tlast, o_tuser}, {exp_d[0], exp_l[0], exp_u[0]});
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                    void'(exp_u.pop_front());
                end
                if (o_tlast) tlast_pos.push_back(beats);
                if (o_tuser[0]) lts_tagged++;
                last_beat_cyc = cyc;
            end
            if (burst_done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (stall_prev && o_tvalid)
                chk("stall_stable", {o_tdata, o_tlast, o_tuser}, prev_out);
            stall_prev = o_tvalid && !o_tready;
            prev_out   = {o_tdata, o_tlast, o_tuser};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_in(logic [31:0] d, bit m);
        in_d.push_back(d);
        in_m.push_back(m);
    endtask

    task automatic push_exp(logic [31:0] d, bit l, logic [1:0] u);
        exp_d.push_back(d);
        exp_l.push_back(l);
        exp_u.push_back(u);
    endtask

    // Builds the input stream of one burst and the beats it must produce.
    // mark_at (1-based) places a marker on that beat of the first data symbol.
    task automatic gen_burst(int ns, int cp, int junk, int mark_at, bit cont);
        logic [31:0] d;
        if (!cont) begin
            for (int i = 0; i < junk; i++) push_in($urandom, 1'b0);
            push_in($urandom, 1'b1);
        end
        for (int i = 1; i < GI; i++) push_in($urandom, 1'b0);
        for (int i = 0; i < LTN * FFT; i++) begin
            d = $urandom;
            push_in(d, 1'b0);
            push_exp(d, (i % FFT) == FFT - 1, 2'b01);
        end
        for (int s = 0; s < ns; s++) begin
            for (int i = 0; i < cp; i++) push_in($urandom, 1'b0);
            for (int i = 0; i < FFT; i++) begin
                d = $urandom;
                if (s == 0 && mark_at != 0 && i == mark_at - 1) begin
                    push_in(d, 1'b1);
`ifdef OFDM_FRAMER_RETRIGGER_EN
                    push_exp(d, 1'b1, 2'b10);
                    return;
`else
                    push_exp(d, i == FFT - 1, 2'b00);
`endif
                end else begin
                    push_in(d, 1'b0);
                    push_exp(d, i == FFT - 1, 2'b00);
                end
            end
        end
        done_exp++;
    endtask

    task automatic set_write(logic [7:0] a, logic [31:0] v);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = a; set_data = v;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic reset_stats();
        done_exp = 0; done_seen = 0; beats = 0; lts_tagged = 0;
        tlast_pos.delete();
    endtask

    // Drives the queued stream, holding a presented beat until it is accepted.
    task automatic run_stream(int rdy_pct, int max_cyc);
        int n = 0;
        bit hold = 1'b0;
        @(posedge clk); #1;
        while ((in_d.size() > 0 || exp_d.size() > 0 || busy) && !abort) begin
            if (!hold) begin
                if (in_d.size() > 0 && $urandom_range(99) < 85) begin
                    i_tvalid = 1'b1; i_tdata = in_d[0]; i_tlast = in_m[0];
                end else begin
                    i_tvalid = 1'b0; i_tlast = 1'b0;
                end
            end
            o_tready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (i_tvalid && i_tready && aresetn) begin
                void'(in_d.pop_front());
                void'(in_m.pop_front());
                hold = 1'b0;
            end else begin
                hold = i_tvalid;
            end
            @(posedge clk); #1;
            n++;
            if (n > max_cyc) begin
                chk("stream_timeout", 64'(n), 64'(max_cyc));
                break;
            end
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
    endtask

    task automatic wait_beats(int target);
        int n = 0;
        while (beats < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("beats_reached", 64'(beats >= target), 64'd1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_i_tready"}, 64'(i_tready), 64'd1);
        chk({tag, "_o_tvalid"}, 64'(o_tvalid), 64'd0);
        chk({tag, "_o_tlast"}, 64'(o_tlast), 64'd0);
        chk({tag, "_o_tuser"}, 64'(o_tuser), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_burst_done"}, 64'(burst_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        aresetn = 1'b1;

        // Normal burst, full-rate output.
        set_write(8'd9, 32'd16);
        set_write(8'd8, 32'd3);
        reset_stats();
        gen_burst(3, 16, 5, 0, 1'b0);
        chk("model_in_len", 64'(in_d.size()), 64'd405);
        chk("model_out_len", 64'(exp_d.size()), 64'd320);
        run_stream(100, 5000);
        chk("normal_beats", 64'(beats), 64'd320);
        chk("normal_tlast_cnt", 64'(tlast_pos.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            chk("normal_tlast_pos", 64'((k < tlast_pos.size()) ? tlast_pos[k] : -1),
                64'(64 * (k + 1)));
        chk("normal_lts_tagged", 64'(lts_tagged), 64'd128);
        chk("normal_done", 64'(done_seen), 64'(done_exp));
        chk("normal_done_cnt", 64'(done_seen), 64'd1);
        chk("done_latency", 64'(done_cyc - last_beat_cyc), 64'd1);
        chk("normal_drained", 64'(exp_d.size()), 64'd0);

        // Same burst under 50% output backpressure.
        reset_stats();
        gen_burst(3, 16, 0, 0, 1'b0);
        run_stream(50, 10000);
        chk("bp_beats", 64'(beats), 64'd320);
        chk("bp_done", 64'(done_seen), 64'd1);

        // num_symbols = 0: only the training symbols.
        set_write(8'd8, 32'd0);
        reset_stats();
        gen_burst(0, 16, 1, 0, 1'b0);
        run_stream(100, 5000);
        chk("nosym_beats", 64'(beats), 64'd128);
        chk("nosym_done", 64'(done_seen), 64'd1);

        // cp_len = 0: four back-to-back packets.
        set_write(8'd9, 32'd0);
        set_write(8'd8, 32'd2);
        reset_stats();
        gen_burst(2, 0, 2, 0, 1'b0);
        chk("model_nocp_in_len", 64'(in_d.size()), 64'd290);
        run_stream(70, 5000);
        chk("nocp_beats", 64'(beats), 64'd256);
        chk("nocp_tlast_cnt", 64'(tlast_pos.size()), 64'd4);
        chk("nocp_done", 64'(done_seen), 64'd1);

        // Settings written mid-burst affect only the following burst.
        set_write(8'd9, 32'd16);
        set_write(8'd8, 32'd3);
        reset_stats();
        gen_burst(3, 16, 0, 0, 1'b0);
        gen_burst(1, 16, 3, 0, 1'b0);
        fork
            run_stream(100, 10000);
            begin
                wait_beats(200);
                set_write(8'd8, 32'd1);
            end
        join
        chk("midwrite_beats", 64'(beats), 64'd512);
        chk("midwrite_done", 64'(done_seen), 64'd2);

        // Marker on data-symbol beat 20.
        set_write(8'd8, 32'd3);
        reset_stats();
        gen_burst(3, 16, 0, 20, 1'b0);
`ifdef OFDM_FRAMER_RETRIGGER_EN
        gen_burst(3, 16, 0, 0, 1'b1);
`endif
        run_stream(80, 10000);
`ifdef OFDM_FRAMER_RETRIGGER_EN
        chk("retrig_beats", 64'(beats), 64'd468);
        chk("retrig_tlast_pos", 64'((tlast_pos.size() > 2) ? tlast_pos[2] : -1), 64'd148);
`else
        chk("retrig_beats", 64'(beats), 64'd320);
        chk("retrig_tlast_pos", 64'((tlast_pos.size() > 2) ? tlast_pos[2] : -1), 64'd192);
`endif
        chk("retrig_done", 64'(done_seen), 64'd1);

        // Asynchronous reset during a data symbol.
        reset_stats();
        gen_burst(3, 16, 0, 0, 1'b0);
        fork
            run_stream(100, 5000);
            begin
                wait_beats(150);
                @(posedge clk); #3;
                aresetn = 1'b0;
                #1;
                chk_reset_outputs("midreset");
                abort = 1'b1;
            end
        join
        in_d.delete(); in_m.delete();
        exp_d.delete(); exp_l.delete(); exp_u.delete();
        @(posedge clk); #1;
        aresetn = 1'b1;
        abort = 1'b0;
        chk("post_reset_busy", 64'(busy), 64'd0);
        set_write(8'd9, 32'd0);
        set_write(8'd8, 32'd2);
        reset_stats();
        gen_burst(2, 0, 1, 0, 1'b0);
        run_stream(100, 5000);
        chk("post_reset_beats", 64'(beats), 64'd256);
        chk("post_reset_done", 64'(done_seen), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofdm_symbol_framer.md
# ofdm_symbol_framer

Burst sequencer placed directly after the OFDM peak detector's AGC output, and before the FFT. On each detector trigger marker it frames the burst into FFT-sized packets:
- discards the long-preamble guard interval;
- passes the two long training symbols, tagged;
- strips the cyclic prefix from each data symbol and passes a programmed number of data symbols;
- returns to idle.

## Interface
Parameters:
- WIDTH_SAMPLE, 16, component width; sample is 2*WIDTH_SAMPLE (sc16).
- FFT_LEN, 64, samples per symbol packet.
- LTS_GI_LEN, 32, long-preamble guard samples discarded after trigger.
- LTS_NUM, 2, long training symbols passed.
- SR_NUM_SYMBOLS, 8, settings address of data symbol count (bits [11:0]).
- SR_CP_LEN, 9, settings address of cyclic prefix length (bits [7:0]).

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  2*WIDTH_SAMPLE  gated/AGC'd samples.
- i_tlast  in  1  trigger marker, set on first long-preamble sample.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  2*WIDTH_SAMPLE  framed samples.
- o_tlast  out  1  last sample of symbol packet.
- o_tuser  out  2  [0] long training symbol, [1] aborted packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- busy  out  1  high in any non-idle state.
- burst_done  out  1  one-cycle pulse when a burst completes normally.

## Operation
- Settings registers use setting_reg semantics, with reset value 0. Both values are latched into working copies when the trigger sample is accepted, so mid-burst writes affect only the next burst.
- A beat is accepted when i_tvalid & i_tready.
- Drop states: i_tready=1, o_tvalid=0.
- Pass states: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready (combinational, zero latency).
- States:
  - S_IDLE (drop): on an accepted beat with i_tlast=1, the sample counts as GI index 0. Go to S_LTS_GI, or to S_LTS if LTS_GI_LEN=1.
  - S_LTS_GI (drop): after LTS_GI_LEN total samples, go to S_LTS.
  - S_LTS (pass): o_tuser[0]=1. o_tlast is set on every FFT_LEN-th beat. After LTS_NUM packets:
    - go to S_CP if num_symbols≠0 and cp_len≠0;
    - go to S_SYM if num_symbols≠0 and cp_len=0;
    - go to S_DONE otherwise.
  - S_CP (drop): drop cp_len samples, then go to S_SYM.
  - S_SYM (pass): o_tuser[0]=0. After FFT_LEN beats, o_tlast=1 and the symbol counter increments. Go to S_DONE when the counter equals num_symbols, else go to S_CP (or S_SYM if cp_len=0).
  - S_DONE: burst_done=1 for one cycle, no beat consumed, then go to S_IDLE.
- cp_len > 255 is impossible by width. cp_len ≥ FFT_LEN is legal (just drops more).
- Sample counter width is clog2(max(FFT_LEN, LTS_GI_LEN, 256)). Symbol counter is 12 bits.
- In S_IDLE, unmarked samples are silently discarded.

## Timing
- Reset values: state S_IDLE, all counters 0, o_tvalid=0, o_tlast=0, o_tuser=0, busy=0, burst_done=0, i_tready=1.
- Data latency is 0 cycles in pass states; o_tlast and o_tuser are decoded from registered counters.
- Backpressure: counters advance only on accepted beats. A stalled o_tready holds o_tdata/o_tlast/o_tuser stable while o_tvalid=1.
- busy rises the cycle after trigger acceptance and falls the cycle after S_DONE.
- Asserting aresetn low mid-burst returns immediately to reset values. No tlast is emitted for the truncated packet.
- Every normal burst outputs exactly (LTS_NUM+num_symbols)*FFT_LEN beats and consumes LTS_GI_LEN + LTS_NUM*FFT_LEN + num_symbols*(cp_len+FFT_LEN) beats.

## Configuration
- OFDM_FRAMER_RETRIGGER_EN defined:
  - A marked sample (i_tlast=1) accepted in S_LTS_GI or S_CP restarts the burst: settings are re-latched and the sample counts as GI index 0.
  - A marked sample accepted in S_LTS or S_SYM is output with o_tlast=1, o_tuser[1]=1 to close the partial packet, then the burst restarts as above. Its acceptance still requires o_tready.
  - burst_done does not pulse for an aborted burst.
- Undefined: i_tlast is ignored outside S_IDLE and treated as ordinary data. o_tuser[1] is tied to 0.

## Test plan
- Normal burst: cp_len=16, num_symbols=3, trigger then 32+128+3*80 samples. Expect 5 packets of 64 beats with tlast on beats 64/128/192/256/320, o_tuser[0]=1 on the first 128 beats, and burst_done one cycle after the last beat.
- Edge settings: num_symbols=0, so only the 2 LTS packets are output, then burst_done. Then cp_len=0, num_symbols=2: 4 back-to-back packets, no samples dropped.
- Backpressure: random o_tready at 50% during the normal burst. Output sequence is identical to the ungated run, with no beat lost or duplicated.
- Mid-burst settings write: num_symbols changed 3→1 during S_SYM. The current burst still outputs 3 data symbols; the next burst outputs 1.
- Retrigger (macro on): marked sample at data-symbol beat 20. That beat is output with tlast=1, o_tuser=2'b10, no burst_done, and the new burst frames correctly. With the macro off, the same stimulus passes the sample as data and tlast stays at beat 64.
- Async reset asserted mid-S_SYM: outputs go immediately to reset values, and the next marked sample starts a clean burst.
